// File: rtl/sweep_ctrl.sv
// Triangle sweep sequencer for an up/down counter: lo->hi->lo, n passes.
// Optional sawtooth mode when SWEEP_SAW_EN is defined.
module sweep_ctrl #(
  parameter int WIDTH   = 8,
  parameter int SWEEP_W = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [SWEEP_W-1:0] n_sweeps,
  input  logic               pause,
  input  logic               abort,
`ifdef SWEEP_SAW_EN
  input  logic               saw,
`endif
  output logic [WIDTH-1:0]   count,
  output logic               mode,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [SWEEP_W-1:0] sweep_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [SWEEP_W-1:0] n_q, n_d;
  logic [SWEEP_W-1:0] sc_q, sc_d;
  logic [SWEEP_W-1:0] sc_inc;
  logic               mode_q, mode_d;
  logic               err_q, err_d;
  logic               accept;
  logic               last;
  logic               saw_q;

  assign accept = (state_q == IDLE) && start && (lo < hi);
  assign sc_inc = sc_q + 1'b1;
  assign last   = (n_q != '0) && (sc_inc == n_q);

`ifdef SWEEP_SAW_EN
  // Waveform shape is fixed for the whole run once the start is taken
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      saw_q <= 1'b0;
    end else if (accept) begin
      saw_q <= saw;
    end
  end
`else
  assign saw_q = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath updates; abort outranks pause
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mode_d  = mode_q;
    sc_d    = sc_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    n_d     = n_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (lo < hi) begin
            lo_d    = lo;
            hi_d    = hi;
            n_d     = n_sweeps;
            count_d = lo;
            sc_d    = '0;
            mode_d  = 1'b1;
            state_d = UP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      UP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!pause) begin
          if (count_q < hi_q) begin
            count_d = count_q + 1'b1;
          end else if (saw_q) begin
            sc_d    = sc_inc;
            count_d = lo_q;
            state_d = last ? DONE : UP;
          end else begin
            count_d = hi_q - 1'b1;
            mode_d  = 1'b0;
            state_d = DOWN;
          end
        end
      end
      DOWN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!pause) begin
          if (count_q > lo_q) begin
            count_d = count_q - 1'b1;
          end else begin
            sc_d = sc_inc;
            if (last) begin
              state_d = DONE;
            end else begin
              count_d = lo_q + 1'b1;
              mode_d  = 1'b1;
              state_d = UP;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= '0;
      mode_q  <= 1'b1;
      sc_q    <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      n_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      mode_q  <= mode_d;
      sc_q    <= sc_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      n_q     <= n_d;
      err_q   <= err_d;
    end
  end

  assign count     = count_q;
  assign mode      = mode_q;
  assign busy      = (state_q == UP) || (state_q == DOWN);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign sweep_cnt = sc_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Scoreboard bench for sweep_ctrl: driver queues expected outputs,
// a negedge monitor pops and compares them.
module tb_sweep_ctrl;

  logic       clk      = 1'b0;
  logic       clr      = 1'b1;
  logic       start    = 1'b0;
  logic       pause    = 1'b0;
  logic       abort    = 1'b0;
  logic [7:0] lo       = '0;
  logic [7:0] hi       = '0;
  logic [3:0] n_sweeps = '0;
`ifdef SWEEP_SAW_EN
  logic       saw      = 1'b0;
`endif
  logic [7:0] count;
  logic       mode;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] sweep_cnt;

  sweep_ctrl #(.WIDTH(8), .SWEEP_W(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .lo        (lo),
    .hi        (hi),
    .n_sweeps  (n_sweeps),
    .pause     (pause),
    .abort     (abort),
`ifdef SWEEP_SAW_EN
    .saw       (saw),
`endif
    .count     (count),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sweep_cnt (sweep_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [7:0] c;
    logic       m;
    logic       b;
    logic       d;
    logic       e;
    logic [3:0] s;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] tri_c [12] = '{4, 5, 6, 5, 4, 3, 4, 5, 6, 5, 4, 3};
  logic [11:0] tri_m = 12'b000_111_000_111;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got c=%0d m=%b b=%b d=%b e=%b s=%0d want c=%0d m=%b b=%b d=%b e=%b s=%0d",
               nm, act[15:8], act[7], act[6], act[5], act[4], act[3:0],
               exp[15:8], exp[7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  // Monitor: one expected entry per cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      chk(me.nm, {count, mode, busy, done, err, sweep_cnt},
          {me.c, me.m, me.b, me.d, me.e, me.s});
    end
  end

  task automatic cyc(input string nm, input logic s, input logic p,
                     input logic a, input logic [7:0] c, input logic m,
                     input logic b, input logic d, input logic e,
                     input logic [3:0] sc);
    exp_t x;
    @(negedge clk);
    #1;
    start = s;
    pause = p;
    abort = a;
    x.nm = nm;
    x.c  = c;
    x.m  = m;
    x.b  = b;
    x.d  = d;
    x.e  = e;
    x.s  = sc;
    q.push_back(x);
  endtask

  initial begin
    logic [7:0] lc;
    logic       lm;
    logic [3:0] ls;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    cyc("rst_idle", 0, 0, 0, 8'd0, 1, 0, 0, 0, 4'd0);

    // async clear in the middle of an UP ramp
    lo = 8'd3; hi = 8'd6; n_sweeps = 4'd2;
    cyc("rst_up0", 1, 0, 0, 8'd3, 1, 1, 0, 0, 4'd0);
    cyc("rst_up1", 0, 0, 0, 8'd4, 1, 1, 0, 0, 4'd0);
    cyc("rst_up2", 0, 0, 0, 8'd5, 1, 1, 0, 0, 4'd0);
    @(negedge clk);
    @(posedge clk);
    #2 clr = 1'b1;
    #1 chk("async_clr", {count, mode, busy, done, err, sweep_cnt},
           {8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    @(negedge clk);
    #1 clr = 1'b0;
    cyc("rst_after", 0, 0, 0, 8'd0, 1, 0, 0, 0, 4'd0);

    // triangle, two passes
    cyc("tri_start", 1, 0, 0, 8'd3, 1, 1, 0, 0, 4'd0);
    for (int i = 0; i < 12; i++)
      cyc("tri", 0, 0, 0, tri_c[i], tri_m[i], 1, 0, 0,
          (i < 6) ? 4'd0 : 4'd1);
    cyc("tri_done", 0, 0, 0, 8'd3, 0, 0, 1, 0, 4'd2);
    cyc("tri_idle", 0, 0, 0, 8'd3, 0, 0, 0, 0, 4'd2);

    // rejected start
    lo = 8'd9; hi = 8'd9;
    cyc("rej_err", 1, 0, 0, 8'd3, 0, 0, 0, 1, 4'd2);
    cyc("rej_clr", 0, 0, 0, 8'd3, 0, 0, 0, 0, 4'd2);

    // pause then abort (abort together with pause)
    lo = 8'd0; hi = 8'd10; n_sweeps = 4'd0;
    cyc("pa_start", 1, 0, 0, 8'd0, 1, 1, 0, 0, 4'd0);
    for (int i = 1; i <= 4; i++)
      cyc("pa_up", 0, 0, 0, 8'(i), 1, 1, 0, 0, 4'd0);
    for (int i = 0; i < 3; i++)
      cyc("pa_hold", 0, 1, 0, 8'd4, 1, 1, 0, 0, 4'd0);
    for (int i = 5; i <= 7; i++)
      cyc("pa_up2", 0, 0, 0, 8'(i), 1, 1, 0, 0, 4'd0);
    cyc("pa_abort", 0, 1, 1, 8'd7, 1, 0, 0, 0, 4'd0);
    cyc("pa_idle", 0, 0, 0, 8'd7, 1, 0, 0, 0, 4'd0);

    // unbounded toggle with sweep_cnt wrap; start while busy ignored
    lo = 8'd254; hi = 8'd255; n_sweeps = 4'd0;
    cyc("ub_start", 1, 0, 0, 8'd254, 1, 1, 0, 0, 4'd0);
    lc = 8'd254; lm = 1'b1; ls = 4'd0;
    for (int t = 1; t <= 40; t++) begin
      if (t % 2 == 1) begin
        lc = 8'd255; lm = 1'b1; ls = 4'((t - 1) / 2);
      end else begin
        lc = 8'd254; lm = 1'b0; ls = 4'((t - 2) / 2);
      end
      if (t == 10) begin
        lo = 8'd1; hi = 8'd5;
      end
      cyc("ub", (t == 10 || t == 11), 0, 0, lc, lm, 1, 0, 0, ls);
    end
    cyc("ub_abort", 0, 0, 1, lc, lm, 0, 0, 0, ls);

`ifdef SWEEP_SAW_EN
    // sawtooth, two passes
    saw = 1'b1; lo = 8'd1; hi = 8'd3; n_sweeps = 4'd2;
    cyc("saw_start", 1, 0, 0, 8'd1, 1, 1, 0, 0, 4'd0);
    saw = 1'b0;
    cyc("saw", 0, 0, 0, 8'd2, 1, 1, 0, 0, 4'd0);
    cyc("saw", 0, 0, 0, 8'd3, 1, 1, 0, 0, 4'd0);
    cyc("saw", 0, 0, 0, 8'd1, 1, 1, 0, 0, 4'd1);
    cyc("saw", 0, 0, 0, 8'd2, 1, 1, 0, 0, 4'd1);
    cyc("saw", 0, 0, 0, 8'd3, 1, 1, 0, 0, 4'd1);
    cyc("saw_done", 0, 0, 0, 8'd1, 1, 0, 1, 0, 4'd2);
    cyc("saw_idle", 0, 0, 0, 8'd1, 1, 0, 0, 0, 4'd2);
`endif

    for (int i = 0; i < 10; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
